// File: rtl/sm83_irq_pkg.sv
// Shared types and constants for the sm83 interrupt controller.
package sm83_irq_pkg;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        HALT = 2'd1,
        DISP = 2'd2
    } irq_state_e;

    localparam int DISP_STEPS  = 5;
    localparam int CANCEL_STEP = 2;

    typedef logic [2:0] disp_step_t;

endpackage

// File: rtl/sm83_irq_ctrl_if.sv
// Bus between the sm83 core/IF owner (master) and the interrupt controller (slave).
interface sm83_irq_ctrl_if #(
    parameter int NUM_IRQS  = 8,
    parameter int ADR_WIDTH = 16
);
    import sm83_irq_pkg::*;

    logic                 mcyc_end;
    logic                 instr_end;
    logic [NUM_IRQS-1:0]  irq;
    logic [NUM_IRQS-1:0]  ie;
    logic                 ctl_ei;
    logic                 ctl_di;
    logic                 ctl_reti;
    logic                 ctl_halt;

    logic                 take_int;
    disp_step_t           disp_step;
    logic [ADR_WIDTH-1:0] vector;
    logic [NUM_IRQS-1:0]  iack;
    logic                 halted;
    logic                 halt_bug;
    logic                 ime;

    modport master (
        output mcyc_end, instr_end, irq, ie, ctl_ei, ctl_di, ctl_reti, ctl_halt,
        input  take_int, disp_step, vector, iack, halted, halt_bug, ime
    );

    modport slave (
        input  mcyc_end, instr_end, irq, ie, ctl_ei, ctl_di, ctl_reti, ctl_halt,
        output take_int, disp_step, vector, iack, halted, halt_bug, ime
    );

endinterface

// File: rtl/sm83_irq_prio.sv
// Lowest-index-first priority encoder: index, one-hot grant and any-request flag.
module sm83_irq_prio #(
    parameter int N     = 8,
    parameter int SEL_W = 3
) (
    input  logic [N-1:0]     req,
    output logic [SEL_W-1:0] sel,
    output logic [N-1:0]     grant,
    output logic             any
);

    // Scan from the top so the lowest set index is the last (winning) write.
    always_comb begin
        sel   = '0;
        grant = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                sel      = SEL_W'(i);
                grant    = '0;
                grant[i] = 1'b1;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/sm83_irq_ctrl.sv
// sm83 interrupt controller: IME/EI delay, HALT and HALT bug, 5 M-cycle dispatch.
// Define SM83_IRQ_SYNC_EN to put a two-flop synchroniser on every irq line.
module sm83_irq_ctrl
    import sm83_irq_pkg::*;
#(
    parameter int NUM_IRQS   = 8,
    parameter int ADR_WIDTH  = 16,
    parameter int VEC_BASE   = 'h0040,
    parameter int VEC_STRIDE = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    sm83_irq_ctrl_if.slave       bus
);

    localparam int SEL_W = (NUM_IRQS > 1) ? $clog2(NUM_IRQS) : 1;

    logic [NUM_IRQS-1:0]  irq_eff;
    logic [NUM_IRQS-1:0]  pend;
    logic [SEL_W-1:0]     sel;
    logic [NUM_IRQS-1:0]  grant;
    logic                 any;

`ifdef SM83_IRQ_SYNC_EN
    logic [NUM_IRQS-1:0]  irq_s1;
    logic [NUM_IRQS-1:0]  irq_s2;

    always_ff @(posedge clk) begin
        if (reset) begin
            irq_s1 <= '0;
            irq_s2 <= '0;
        end else begin
            irq_s1 <= bus.irq;
            irq_s2 <= irq_s1;
        end
    end

    assign irq_eff = irq_s2;
`else
    assign irq_eff = bus.irq;
`endif

    assign pend = irq_eff & bus.ie;

    sm83_irq_prio #(
        .N     (NUM_IRQS),
        .SEL_W (SEL_W)
    ) u_prio (
        .req   (pend),
        .sel   (sel),
        .grant (grant),
        .any   (any)
    );

    irq_state_e           state,     state_nxt;
    logic                 ime,       ime_nxt;
    logic                 ei_delay,  ei_delay_nxt;
    disp_step_t           disp_step, disp_step_nxt;
    logic [ADR_WIDTH-1:0] vector,    vector_nxt;
    logic [NUM_IRQS-1:0]  grant_lat, grant_lat_nxt;
    logic [NUM_IRQS-1:0]  iack,      iack_nxt;
    logic                 halt_bug,  halt_bug_nxt;

    logic                 boundary;
    logic [ADR_WIDTH-1:0] vec_calc;

    assign boundary = bus.mcyc_end & bus.instr_end;
    assign vec_calc = ADR_WIDTH'(VEC_BASE) + ADR_WIDTH'(VEC_STRIDE) * ADR_WIDTH'(sel);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= RUN;
            ime       <= 1'b0;
            ei_delay  <= 1'b0;
            disp_step <= '0;
            vector    <= '0;
            grant_lat <= '0;
            iack      <= '0;
            halt_bug  <= 1'b0;
        end else begin
            state     <= state_nxt;
            ime       <= ime_nxt;
            ei_delay  <= ei_delay_nxt;
            disp_step <= disp_step_nxt;
            vector    <= vector_nxt;
            grant_lat <= grant_lat_nxt;
            iack      <= iack_nxt;
            halt_bug  <= halt_bug_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        ime_nxt       = ime;
        ei_delay_nxt  = ei_delay;
        disp_step_nxt = disp_step;
        vector_nxt    = vector;
        grant_lat_nxt = grant_lat;
        iack_nxt      = '0;
        halt_bug_nxt  = 1'b0;

        unique case (state)
            RUN: begin
                if (boundary) begin
                    if (bus.ctl_di) begin
                        ime_nxt      = 1'b0;
                        ei_delay_nxt = 1'b0;
                    end else if (bus.ctl_ei) begin
                        ei_delay_nxt = 1'b1;
                    end else if (bus.ctl_reti) begin
                        ime_nxt = 1'b1;
                    end else if (ei_delay) begin
                        ime_nxt      = 1'b1;
                        ei_delay_nxt = 1'b0;
                    end

                    // Tests the pre-boundary ime, so the instruction after EI runs uninterrupted.
                    if (ime && any) begin
                        state_nxt     = DISP;
                        ime_nxt       = 1'b0;
                        ei_delay_nxt  = 1'b0;
                        disp_step_nxt = '0;
                    end else if (bus.ctl_halt) begin
                        if (!ime && any)
                            halt_bug_nxt = 1'b1;
                        else
                            state_nxt = HALT;
                    end
                end
            end

            HALT: begin
                if (bus.mcyc_end && any) begin
                    if (ime) begin
                        state_nxt     = DISP;
                        ime_nxt       = 1'b0;
                        ei_delay_nxt  = 1'b0;
                        disp_step_nxt = '0;
                    end else begin
                        state_nxt = RUN;
                    end
                end
            end

            DISP: begin
                if (bus.mcyc_end) begin
                    // Late re-sample: a request dropped before here cancels the acknowledge.
                    if (disp_step == disp_step_t'(CANCEL_STEP)) begin
                        grant_lat_nxt = grant;
                        vector_nxt    = any ? vec_calc : '0;
                    end
                    if (disp_step == disp_step_t'(DISP_STEPS - 1)) begin
                        iack_nxt      = grant_lat;
                        state_nxt     = RUN;
                        disp_step_nxt = '0;
                    end else begin
                        disp_step_nxt = disp_step + disp_step_t'(1);
                    end
                end
            end

            default: state_nxt = RUN;
        endcase
    end

    assign bus.take_int  = (state == DISP);
    assign bus.halted    = (state == HALT);
    assign bus.disp_step = disp_step;
    assign bus.vector    = vector;
    assign bus.iack      = iack;
    assign bus.halt_bug  = halt_bug;
    assign bus.ime       = ime;

endmodule

// File: tb/tb_sm83_irq_ctrl.sv
// Directed bench for sm83_irq_ctrl: M-cycles of 4 clocks, hand-computed expectations.
module tb_sm83_irq_ctrl;

    logic clk;
    logic reset;

    sm83_irq_ctrl_if #(.NUM_IRQS(8), .ADR_WIDTH(16)) bus ();

    sm83_irq_ctrl #(
        .NUM_IRQS   (8),
        .ADR_WIDTH  (16),
        .VEC_BASE   ('h0040),
        .VEC_STRIDE (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int iack_cnt = 0;

    always @(negedge clk) begin
        if (!reset && (|bus.iack)) iack_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mcyc(input logic iend);
        repeat (3) tick();
        bus.mcyc_end  = 1'b1;
        bus.instr_end = iend;
        tick();
        bus.mcyc_end  = 1'b0;
        bus.instr_end = 1'b0;
        bus.ctl_ei    = 1'b0;
        bus.ctl_di    = 1'b0;
        bus.ctl_reti  = 1'b0;
        bus.ctl_halt  = 1'b0;
    endtask

    task automatic instr(input logic ei, input logic di, input logic reti, input logic halt);
        bus.ctl_ei   = ei;
        bus.ctl_di   = di;
        bus.ctl_reti = reti;
        bus.ctl_halt = halt;
        mcyc(1'b1);
    endtask

    // Run the five dispatch M-cycles, checking the step index and take_int along the way.
    task automatic run_disp(input string tag);
        for (int k = 0; k < 4; k++) begin
            mcyc(1'b0);
            chk({tag, "_step"}, 32'(bus.disp_step), 32'(k + 1));
            chk({tag, "_take"}, 32'(bus.take_int), 32'd1);
        end
        mcyc(1'b0);
        chk({tag, "_take_end"}, 32'(bus.take_int), 32'd0);
    endtask

    int iack_before;

    initial begin
        reset         = 1'b1;
        bus.mcyc_end  = 1'b0;
        bus.instr_end = 1'b0;
        bus.irq       = '0;
        bus.ie        = 8'hFF;
        bus.ctl_ei    = 1'b0;
        bus.ctl_di    = 1'b0;
        bus.ctl_reti  = 1'b0;
        bus.ctl_halt  = 1'b0;
        repeat (3) tick();
        reset = 1'b0;

        chk("rst_ime",    32'(bus.ime),       32'd0);
        chk("rst_take",   32'(bus.take_int),  32'd0);
        chk("rst_halted", 32'(bus.halted),    32'd0);
        chk("rst_vector", 32'(bus.vector),    32'd0);
        chk("rst_step",   32'(bus.disp_step), 32'd0);
        chk("rst_iack",   32'(bus.iack),      32'd0);

        // EI delay with nothing pending: ime rises after the following instruction.
        instr(1, 0, 0, 0);
        chk("ei_ime_n",   32'(bus.ime), 32'd0);
        instr(0, 0, 0, 0);
        chk("ei_ime_n1",  32'(bus.ime), 32'd1);

        // Priority: bits 2 and 4 pending, bit 2 wins -> 0x40 + 2*8.
        bus.irq = 8'b0001_0100;
        instr(0, 0, 0, 0);
        chk("pri_take",  32'(bus.take_int),  32'd1);
        chk("pri_step0", 32'(bus.disp_step), 32'd0);
        chk("pri_ime",   32'(bus.ime),       32'd0);
        run_disp("pri");
        chk("pri_vector", 32'(bus.vector), 32'h0050);
        chk("pri_iack",   32'(bus.iack),   32'h04);
        tick();
        chk("pri_iack_1clk", 32'(bus.iack), 32'h00);
        chk("pri_iack_cnt",  32'(iack_cnt), 32'd1);
        bus.irq = '0;

        // EI with irq pending: no dispatch at N+1, dispatch at N+2.
        bus.irq = 8'h01;
        instr(1, 0, 0, 0);
        chk("eid_take_n",  32'(bus.take_int), 32'd0);
        instr(0, 0, 0, 0);
        chk("eid_take_n1", 32'(bus.take_int), 32'd0);
        chk("eid_ime_n1",  32'(bus.ime),      32'd1);
        instr(0, 0, 0, 0);
        chk("eid_take_n2", 32'(bus.take_int), 32'd1);
        run_disp("eid");
        chk("eid_vector", 32'(bus.vector), 32'h0040);
        chk("eid_iack",   32'(bus.iack),   32'h01);
        bus.irq = '0;
        tick();

        // EI then DI: ime stays 0 even with a request pending.
        bus.irq = 8'h01;
        instr(1, 0, 0, 0);
        instr(0, 1, 0, 0);
        instr(0, 0, 0, 0);
        chk("eidi_ime",  32'(bus.ime),      32'd0);
        chk("eidi_take", 32'(bus.take_int), 32'd0);
        bus.irq = '0;

        // Cancellation: irq[1] dropped during step 1.
        instr(0, 0, 1, 0);
        chk("reti_ime", 32'(bus.ime), 32'd1);
        bus.irq = 8'h02;
        instr(0, 0, 0, 0);
        chk("can_take", 32'(bus.take_int), 32'd1);
        iack_before = iack_cnt;
        mcyc(1'b0);
        bus.irq = '0;
        mcyc(1'b0);
        mcyc(1'b0);
        chk("can_vector", 32'(bus.vector), 32'h0000);
        mcyc(1'b0);
        mcyc(1'b0);
        chk("can_take_end", 32'(bus.take_int), 32'd0);
        tick();
        chk("can_no_iack", 32'(iack_cnt), 32'(iack_before));

        // HALT with ime=0, wake on irq[3] without dispatch.
        instr(0, 0, 0, 1);
        chk("hlt_halted", 32'(bus.halted), 32'd1);
        mcyc(1'b0);
        chk("hlt_stay",   32'(bus.halted), 32'd1);
        bus.irq = 8'h08;
        mcyc(1'b0);
        chk("hlt_wake",   32'(bus.halted),   32'd0);
        chk("hlt_nodisp", 32'(bus.take_int), 32'd0);
        mcyc(1'b0);
        chk("hlt_nodisp2", 32'(bus.take_int), 32'd0);
        bus.irq = '0;

        // HALT bug: ime=0 with irq[0] pending.
        bus.irq = 8'h01;
        instr(0, 0, 0, 1);
        chk("hbug_pulse",  32'(bus.halt_bug), 32'd1);
        chk("hbug_halted", 32'(bus.halted),   32'd0);
        tick();
        chk("hbug_1clk",   32'(bus.halt_bug), 32'd0);
        bus.irq = '0;

        // HALT with ime=1 wakes straight into dispatch of the lowest-priority channel.
        instr(0, 0, 1, 0);
        instr(0, 0, 0, 1);
        chk("hdisp_halted", 32'(bus.halted), 32'd1);
        bus.irq = 8'h80;
        mcyc(1'b0);
        chk("hdisp_take", 32'(bus.take_int), 32'd1);
        chk("hdisp_wake", 32'(bus.halted),   32'd0);
        run_disp("hdisp");
        chk("hdisp_vector", 32'(bus.vector), 32'h0078);
        chk("hdisp_iack",   32'(bus.iack),   32'h80);
        bus.irq = '0;
        tick();

        // Reset at step 3 of a dispatch aborts it.
        instr(0, 0, 1, 0);
        bus.irq = 8'h10;
        instr(0, 0, 0, 0);
        mcyc(1'b0);
        mcyc(1'b0);
        mcyc(1'b0);
        chk("rmid_step",   32'(bus.disp_step), 32'd3);
        chk("rmid_vec_pre", 32'(bus.vector),   32'h0060);
        iack_before = iack_cnt;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rmid_take",   32'(bus.take_int), 32'd0);
        chk("rmid_ime",    32'(bus.ime),      32'd0);
        chk("rmid_vector", 32'(bus.vector),   32'h0000);
        chk("rmid_iack",   32'(bus.iack),     32'h00);
        repeat (3) mcyc(1'b1);
        chk("rmid_no_iack", 32'(iack_cnt),     32'(iack_before));
        chk("rmid_nodisp",  32'(bus.take_int), 32'd0);
        bus.irq = '0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sm83_irq_ctrl.md
Name: sm83_irq_ctrl

Overview:
- Parametrised interrupt controller for the sm83 core. It generalises the fixed 8-line irq/iack pair to NUM_IRQS channels with a configurable vector table.
- Owns IME, the EI one-instruction delay, HALT entry/wake-up, the HALT-bug condition, and the 5-M-cycle dispatch sequence with late cancellation.
- Sits beside sm83_control. The control unit sees take_int and vector; the interrupt-flag owner sees iack.

Parameters:
- NUM_IRQS, 8: number of interrupt channels; index 0 has the highest priority.
- ADR_WIDTH, 16: width of the vector output.
- VEC_BASE, 'h0040: vector address of channel 0.
- VEC_STRIDE, 8: address step between consecutive channel vectors.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- mcyc_end  in  1  single-cycle pulse on the last clock of every M-cycle (T4)
- instr_end  in  1  the current M-cycle is the last of an instruction; qualified by mcyc_end
- irq  in  NUM_IRQS  level requests (IF bits)
- ie  in  NUM_IRQS  enable mask (IE register)
- ctl_ei  in  1  EI executing; qualified by instr_end&mcyc_end
- ctl_di  in  1  DI executing; same qualification
- ctl_reti  in  1  RETI executing; same qualification
- ctl_halt  in  1  HALT executing; same qualification
- take_int  out  1  high during all dispatch M-cycles
- disp_step  out  3  dispatch M-cycle index, 0..4
- vector  out  ADR_WIDTH  dispatch target; valid from step 4
- iack  out  NUM_IRQS  one-hot one-clock acknowledge
- halted  out  1  core is stalled in HALT
- halt_bug  out  1  one-clock pulse: the next opcode fetch must not increment PC
- ime  out  1  interrupt master enable

Behaviour:
- pend = irq & ie. sel = lowest set index of pend. "any" = |pend.
- Reset values: ime=0, ei_delay=0, state=RUN, take_int=0, disp_step=0, vector=0, iack=0, halted=0, halt_bug=0.
- States are RUN, HALT and DISP. Every transition occurs only on clocks where mcyc_end=1, except the iack and halt_bug pulses.
- IME handling on an instruction boundary (instr_end&mcyc_end):
  - ctl_di clears ime and ei_delay.
  - ctl_ei sets ei_delay.
  - ctl_reti sets ime immediately.
  - Otherwise, if ei_delay=1, then ime<=1 and ei_delay<=0.
  - As a result, ime rises at the end of the instruction following EI.
  - EI followed by DI leaves ime=0.
- RUN to DISP: on instr_end&mcyc_end with ime=1 and any=1.
  - Dispatch has priority over the ctl_halt transition.
  - The ime=1 test uses the value before this boundary's update, so the instruction immediately after EI cannot be interrupted.
  - On entry: ime<=0, ei_delay<=0, disp_step<=0.
- DISP sequencing:
  - disp_step increments on each mcyc_end.
  - Steps 0 and 1 are internal cycles, step 2 pushes PC.hi, step 3 pushes PC.lo, step 4 loads PC.
- DISP cancellation: at the mcyc_end ending step 2, sel and any are re-sampled and latched.
  - If any=1: vector<=VEC_BASE+sel*VEC_STRIDE, computed in ADR_WIDTH bits with truncation.
  - If any=0 (cancelled): vector<=0 and no iack is issued.
- DISP completion: at the mcyc_end ending step 4:
  - iack[sel_latched] pulses for exactly one clock, unless the dispatch was cancelled.
  - State returns to RUN and take_int falls.
- RUN to HALT: ctl_halt on instr_end&mcyc_end.
  - If ime=0 and any=1 at that point, do not halt. Pulse halt_bug for one clock and stay in RUN.
  - Otherwise enter HALT with halted=1.
- HALT exit: leave on the first mcyc_end with any=1, regardless of ime.
  - If ime=1, go straight to DISP.
  - Else go to RUN (execution continues, no dispatch).
- Simultaneous events: irq bits changing mid M-cycle have no effect; only mcyc_end samples matter. Multiple pending bits resolve to the lowest index.
- Reset in the middle of DISP aborts the sequence: no iack is issued and all outputs take their reset values on the next clock.

Optional Feature:
- Macro SM83_IRQ_SYNC_EN.
- When defined, irq passes through a two-flop synchroniser per bit, reset to 0, before pend is formed. This adds 2 clk of request latency for asynchronous sources.
- When undefined, irq is used combinationally, with zero added latency.

Decomposition:
- Package sm83_irq_pkg holds:
  - the state enum {RUN, HALT, DISP};
  - constants DISP_STEPS=5 and CANCEL_STEP=2;
  - the disp_step_t typedef.
- Sub-module sm83_irq_prio: a parametrised lowest-index-first priority encoder producing the sel index, the one-hot grant and "any". It is purely combinational and reused for both iack and vector.

Test Plan:
- Priority and vector: ime=1, ie='hFF, irq='b00010100 at instr_end -> take_int for 5 M-cycles, vector=0x0050, iack='b00000100 one clock at the end of step 4, ime=0.
- EI delay: EI at boundary N with irq pending -> no dispatch at N+1, ime=1 after N+1, dispatch at N+2. Separately, EI then DI -> ime stays 0, no dispatch.
- Cancel: dispatch of irq bit 1 starts; irq dropped to 0 during step 1 -> vector=0x0000, iack never pulses, state returns to RUN.
- HALT wake, ime=0: HALT with pend=0 -> halted=1. Raise irq[3]&ie[3] -> halted=0 at the next mcyc_end, no take_int.
- HALT bug: ime=0, irq[0]&ie[0]=1, HALT at boundary -> halt_bug single-clock pulse, halted stays 0.
- Reset mid-dispatch at step 3 -> next clock take_int=0, ime=0, vector=0, no iack. With SM83_IRQ_SYNC_EN, irq-to-dispatch eligibility is delayed by 2 clk.
